// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, constants and the parity helper for the data memory
// controller. The parity word is only used when DMEM_PARITY_EN is defined.
package dmem_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam int WAIT_CNT_W = 4;

    // Widest data word the parity helper accepts; narrower words are zero-extended,
    // which does not change the XOR reduction.
    localparam int PAR_MAX_W = 64;

    // Even parity bit: makes the total count of ones (data + bit) even.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x WIDTH single-port RAM with synchronous write and a
// registered, enable-gated read port. Storage contents are never reset; the
// controller clears them with a sweep after reset.
module dmem_array #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rdata_r;

    // Write port and registered read port; read output holds until the next read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        if (re) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: request/response data memory controller with programmable wait
// states, address range checking and a clear sweep after every reset.
// Optional feature: define DMEM_PARITY_EN to store an even parity bit per word
// and flag parity mismatches on reads through rsp_err.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 5,
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_busy
);

`ifdef DMEM_PARITY_EN
    localparam int ARR_W = DATA_W + 1;
`else
    localparam int ARR_W = DATA_W;
`endif

    localparam logic [WAIT_CNT_W-1:0] WS_LOAD   = WAIT_CNT_W'(WAIT_STATES);
    localparam logic [ADDR_W-1:0]     LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t                  state_r;
    logic [ADDR_W-1:0]       cnt_r;
    logic [WAIT_CNT_W-1:0]   wcnt_r;
    logic                    wr_r;
    logic [ADDR_W-1:0]       addr_r;
    logic [DATA_W-1:0]       wdata_r;
    logic                    req_ready_r;
    logic                    rsp_valid_r;
    logic [DATA_W-1:0]       data_r;
    logic                    err_r;
    logic                    from_arr_r;
    logic                    init_busy_r;

    logic                    acc_now_s;
    logic                    acc_wr_s;
    logic [ADDR_W-1:0]       acc_addr_s;
    logic [DATA_W-1:0]       acc_wdata_s;
    logic                    in_range_s;
    logic                    arr_we_s;
    logic                    arr_re_s;
    logic [ADDR_W-1:0]       arr_addr_s;
    logic [DATA_W-1:0]       arr_data_s;
    logic [ARR_W-1:0]        arr_wword_s;
    logic [ARR_W-1:0]        arr_rword_s;
    logic [DATA_W-1:0]       rd_data_s;
    logic                    par_err_s;

    // Select the access operands and decide whether the array access happens at this edge.
    always_comb begin
        acc_now_s   = 1'b0;
        acc_wr_s    = wr_r;
        acc_addr_s  = addr_r;
        acc_wdata_s = wdata_r;
        case (state_r)
            IDLE: begin
                acc_wr_s    = req_write;
                acc_addr_s  = req_addr;
                acc_wdata_s = req_wdata;
                acc_now_s   = req_valid && req_ready_r && (WS_LOAD == {WAIT_CNT_W{1'b0}});
            end
            WAIT: begin
                acc_now_s = (wcnt_r == WAIT_CNT_W'(1));
            end
            default: begin
                acc_now_s = 1'b0;
            end
        endcase
    end

    // A fully populated address space can never be out of range.
    if (DEPTH >= (1 << ADDR_W)) begin : g_full_range
        assign in_range_s = 1'b1;
    end else begin : g_part_range
        localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
        assign in_range_s = (acc_addr_s < DEPTH_A);
    end

    // Drive the array: sweep writes during INIT, otherwise the in-range access.
    always_comb begin
        arr_we_s   = 1'b0;
        arr_re_s   = 1'b0;
        arr_addr_s = acc_addr_s;
        arr_data_s = acc_wdata_s;
        if (state_r == INIT) begin
            arr_we_s   = 1'b1;
            arr_addr_s = cnt_r;
            arr_data_s = {DATA_W{1'b0}};
        end else begin
            arr_we_s = acc_now_s && acc_wr_s && in_range_s;
            arr_re_s = acc_now_s && !acc_wr_s && in_range_s;
        end
    end

`ifdef DMEM_PARITY_EN
    assign arr_wword_s = {even_parity({{(PAR_MAX_W-DATA_W){1'b0}}, arr_data_s}), arr_data_s};
    assign rd_data_s   = arr_rword_s[DATA_W-1:0];
    assign par_err_s   = even_parity({{(PAR_MAX_W-DATA_W){1'b0}}, rd_data_s}) != arr_rword_s[DATA_W];
`else
    assign arr_wword_s = arr_data_s;
    assign rd_data_s   = arr_rword_s;
    assign par_err_s   = 1'b0;
`endif

    dmem_array #(
        .WIDTH  (ARR_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we_s),
        .re    (arr_re_s),
        .addr  (arr_addr_s),
        .wdata (arr_wword_s),
        .rdata (arr_rword_s)
    );

    // Controller FSM with registered handshake and response state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= INIT;
            cnt_r       <= {ADDR_W{1'b0}};
            wcnt_r      <= {WAIT_CNT_W{1'b0}};
            wr_r        <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= {DATA_W{1'b0}};
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            data_r      <= {DATA_W{1'b0}};
            err_r       <= 1'b0;
            from_arr_r  <= 1'b0;
            init_busy_r <= 1'b1;
        end else begin
            rsp_valid_r <= 1'b0;
            // Response payload is captured at the access edge; reads take data from the array port.
            if (acc_now_s) begin
                if (!in_range_s) begin
                    data_r     <= {DATA_W{1'b0}};
                    err_r      <= 1'b1;
                    from_arr_r <= 1'b0;
                end else if (acc_wr_s) begin
                    data_r     <= acc_wdata_s;
                    err_r      <= 1'b0;
                    from_arr_r <= 1'b0;
                end else begin
                    err_r      <= 1'b0;
                    from_arr_r <= 1'b1;
                end
            end
            case (state_r)
                INIT: begin
                    cnt_r <= cnt_r + ADDR_W'(1);
                    if (cnt_r == LAST_ADDR) begin
                        state_r     <= IDLE;
                        req_ready_r <= 1'b1;
                        init_busy_r <= 1'b0;
                    end
                end
                IDLE: begin
                    if (req_valid && req_ready_r) begin
                        wr_r        <= req_write;
                        addr_r      <= req_addr;
                        wdata_r     <= req_wdata;
                        wcnt_r      <= WS_LOAD;
                        req_ready_r <= 1'b0;
                        if (WS_LOAD == {WAIT_CNT_W{1'b0}}) begin
                            state_r     <= RESP;
                            rsp_valid_r <= 1'b1;
                        end else begin
                            state_r <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    wcnt_r <= wcnt_r - WAIT_CNT_W'(1);
                    if (wcnt_r == WAIT_CNT_W'(1)) begin
                        state_r     <= RESP;
                        rsp_valid_r <= 1'b1;
                    end
                end
                RESP: begin
                    state_r     <= IDLE;
                    req_ready_r <= 1'b1;
                end
                default: begin
                    state_r     <= INIT;
                    cnt_r       <= {ADDR_W{1'b0}};
                    req_ready_r <= 1'b0;
                    init_busy_r <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign init_busy = init_busy_r;
    assign rsp_rdata = from_arr_r ? rd_data_s : data_r;
    assign rsp_err   = err_r | (from_arr_r & par_err_s);

endmodule
